simd_add_sequencer: RTL and testbench

SIMD_ADD_SEQUENCER -- requirements
Module: simd_add_sequencer
Interface
REQ-001 Parameter MAX_WIDTH, default 64, adder word width in bits; byte granularity fixed at 8; SEW_WIDTH = $clog2(MAX_WIDTH/8)+1.
REQ-002 Parameter MAX_VL, default 64, maximum elements per instruction.
REQ-003 Parameter ADDR_WIDTH, default 5, register-file word address width.
REQ-004 clk  in  1  single clock.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 instr_valid  in  1  instruction offered.
REQ-007 instr_ready  out  1  instruction accepted when both high.
REQ-008 instr_op  in  2  ADD=0, SUB=1, RSUB=2, ADC=3.
REQ-009 instr_vsew  in  2  element width 8<<vsew bits.
REQ-010 instr_vl  in  $clog2(MAX_VL)+1  element count; values >MAX_VL clamp to MAX_VL.
REQ-011 instr_vm  in  1  1 = unmasked.
REQ-012 instr_vmask  in  MAX_VL  per-element mask/carry bits (v0).
REQ-013 instr_vs1  in  ADDR_WIDTH  base word of operand B.
REQ-014 instr_vs2  in  ADDR_WIDTH  base word of operand A.
REQ-015 instr_vd  in  ADDR_WIDTH  base word of destination.
REQ-016 rd_en  out  1  read request; data returns next cycle directly into the adder opA/opB.
REQ-017 rd_addr_a  out  ADDR_WIDTH  vs2 + chunk, modulo 2^ADDR_WIDTH.
REQ-018 rd_addr_b  out  ADDR_WIDTH  vs1 + chunk, modulo 2^ADDR_WIDTH.
REQ-019 add_sub / add_rev / add_carry  out  1 each  adder controls.
REQ-020 add_sew  out  SEW_WIDTH  thermometer SEW: vsew 0->1111, 1->0111, 2->0011, 3->0001.
REQ-021 add_mask  out  MAX_WIDTH/8  per-byte carry-in vector.
REQ-022 add_result  in  MAX_WIDTH  adder sum.
REQ-023 wr_valid / wr_ready  out / in  1  write handshake.
REQ-024 wr_addr  out  ADDR_WIDTH  vd + chunk, modulo 2^ADDR_WIDTH.
REQ-025 wr_data / wr_be  out  MAX_WIDTH / MAX_WIDTH/8  result word and byte enables.
REQ-026 done  out  1  one-cycle completion pulse.
Function
REQ-027 FSM states IDLE, READ, EXEC, WRITE, FIN; instr_ready SHALL be 1 only in IDLE.
REQ-028 On acceptance latch all instr_* fields, chunk=0, nchunks=((vl<<vsew)+7)>>3; nchunks=0 -> FIN, else -> READ.
REQ-029 READ: rd_en=1 for exactly one cycle with rd_addr_a/b valid, then EXEC.
REQ-030 EXEC: add_* valid; wr_data<=add_result and wr_be registered at cycle end; then WRITE.
REQ-031 WRITE: wr_valid=1, wr_addr/wr_data/wr_be held stable until wr_ready; on handshake last chunk -> FIN, else chunk+1 -> READ (minimum 3 cycles per chunk).
REQ-032 FIN: done=1 for one cycle, then IDLE; done follows the last write handshake or vl=0 acceptance by exactly one cycle.
REQ-033 Decode: ADD sub=0 rev=0 carry=0; SUB sub=1 rev=0; RSUB sub=1 rev=1; ADC carry=1 sub=0; held for the whole instruction, all add_* zero in IDLE.
REQ-034 add_mask: for element j of chunk (e = chunk*(8>>vsew)+j), bit j<<vsew = vmask[e] if e<vl, all other bits 0.
REQ-035 wr_be byte b active iff its element e<vl and (vm=1 or op=ADC or vmask[e]=1); a chunk with wr_be=0 is still written.
REQ-036 rd_en, wr_valid, done SHALL never assert in IDLE; no new instruction accepted before FIN completes.
Reset
REQ-037 rst in any state -> IDLE next cycle; all outputs 0 except instr_ready=1; in-flight write abandoned, no further rd_en/wr_valid.
Structure
REQ-038 Package simd_add_pkg SHALL hold the op enum, FSM state enum and the vsew-to-thermometer function.
REQ-039 Sub-module simd_add_mask_gen SHALL compute add_mask and wr_be combinationally from vsew, chunk, vl, vm, vmask, op.
Verification
REQ-040 ADD vsew=3 vl=2 vm=1 vs2=4 vs1=8 vd=12, wr_ready=1 -> reads (4,8),(5,9); writes 12,13 with be=0xFF; add_sew=0001; done 1 cycle after 2nd write.
REQ-041 SUB vsew=0 vl=10 vm=0 vmask=0x2AA -> add_sub=1, add_sew=1111; 2 writes, be=0xAA then 0x02.
REQ-042 ADC vsew=1 vl=4 vmask=0b0101 -> add_carry=1, add_mask=0x11, wr_be=0xFF, one write.
REQ-043 wr_ready low 5 cycles in WRITE -> wr_* stable; vl=0 -> no rd_en/wr_valid, done 1 cycle after accept; rst during EXEC -> IDLE next cycle, instr_ready=1, no write.

---
 rtl/simd_add_pkg.sv | 30 +++
 rtl/simd_add_mask_gen.sv | 49 ++++
 rtl/simd_add_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_simd_add_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_add_pkg.sv
// Purpose: shared types and helpers for the SIMD add sequencer (op codes, FSM states, SEW decode).
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package simd_add_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'd0,
        OP_SUB  = 2'd1,
        OP_RSUB = 2'd2,
        OP_ADC  = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_FIN   = 3'd4
    } state_e;

    // Thermometer code for the adder's segment breaks: wider elements clear
    // more of the upper bits (vsew 0 -> all ones, vsew 3 -> only bit 0 set).
    // Callers truncate the result to their own SEW width.
    function automatic logic [7:0] vsew_to_therm(input logic [1:0] vsew, input int sew_w);
        logic [8:0] ones;
        ones = (9'd1 << (sew_w - int'(vsew))) - 9'd1;
        return ones[7:0];
    endfunction

endpackage

// File: rtl/simd_add_mask_gen.sv
// Purpose: per-byte carry-in mask and write byte enables for one adder word (chunk).
// Latency: combinational.
// Backpressure: none; pure function of the latched instruction and chunk index.
//
// Ports: i_vsew element width code, i_chunk word index within the vector,
//        i_vl clamped element count, i_vm unmasked flag, i_vmask v0 bits,
//        i_op operation; o_mask carry-in per byte, o_be write enable per byte.
module simd_add_mask_gen
    import simd_add_pkg::*;
#(
    parameter int MAX_WIDTH = 64,
    parameter int MAX_VL    = 64,
    parameter int CHUNK_W   = 10,
    parameter int VL_W      = 7
) (
    input  logic [1:0]             i_vsew,
    input  logic [CHUNK_W-1:0]     i_chunk,
    input  logic [VL_W-1:0]        i_vl,
    input  logic                   i_vm,
    input  logic [MAX_VL-1:0]      i_vmask,
    input  op_e                    i_op,
    output logic [MAX_WIDTH/8-1:0] o_mask,
    output logic [MAX_WIDTH/8-1:0] o_be
);

    localparam int NB    = MAX_WIDTH / 8;
    localparam int VMI_W = $clog2(MAX_VL);

    always_comb begin
        int   w_elem;
        logic w_act;
        logic w_vbit;
        o_mask = '0;
        o_be   = '0;
        w_elem = 0;
        w_act  = 1'b0;
        w_vbit = 1'b0;
        for (int b = 0; b < NB; b++) begin
            // Element index of this byte across the whole vector.
            w_elem = int'(i_chunk) * (NB >> i_vsew) + (b >> i_vsew);
            w_act  = (w_elem < int'(i_vl));
            w_vbit = (w_elem < MAX_VL) ? i_vmask[w_elem[VMI_W-1:0]] : 1'b0;
            o_be[b] = w_act && (i_vm || (i_op == OP_ADC) || w_vbit);
            // Carry-in only lands on the lowest byte of each element.
            o_mask[b] = w_act && w_vbit && (((b >> i_vsew) << i_vsew) == b);
        end
    end

endmodule

// File: rtl/simd_add_sequencer.sv
// Purpose: sequences a vector add/sub over register-file words through an external SIMD adder.
// Latency: accept -> first read 1 cycle; >= 3 cycles per word; done 1 cycle after last write.
// Backpressure: instr_ready only in IDLE; WRITE holds wr_* stable until wr_ready.
//
// Ports: instr_* instruction offer (valid/ready); rd_en/rd_addr_a/b operand read
//        (data lands at the adder next cycle); add_* adder controls and add_result
//        sum; wr_* result write (valid/ready); done one-cycle completion pulse.
module simd_add_sequencer
    import simd_add_pkg::*;
#(
    parameter  int MAX_WIDTH  = 64,
    parameter  int MAX_VL     = 64,
    parameter  int ADDR_WIDTH = 5,
    localparam int SEW_WIDTH  = $clog2(MAX_WIDTH / 8) + 1,
    localparam int VL_W       = $clog2(MAX_VL) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [1:0]             instr_op,
    input  logic [1:0]             instr_vsew,
    input  logic [VL_W-1:0]        instr_vl,
    input  logic                   instr_vm,
    input  logic [MAX_VL-1:0]      instr_vmask,
    input  logic [ADDR_WIDTH-1:0]  instr_vs1,
    input  logic [ADDR_WIDTH-1:0]  instr_vs2,
    input  logic [ADDR_WIDTH-1:0]  instr_vd,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr_a,
    output logic [ADDR_WIDTH-1:0]  rd_addr_b,
    output logic                   add_sub,
    output logic                   add_rev,
    output logic                   add_carry,
    output logic [SEW_WIDTH-1:0]   add_sew,
    output logic [MAX_WIDTH/8-1:0] add_mask,
    input  logic [MAX_WIDTH-1:0]   add_result,
    output logic                   wr_valid,
    input  logic                   wr_ready,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [MAX_WIDTH-1:0]   wr_data,
    output logic [MAX_WIDTH/8-1:0] wr_be,
    output logic                   done
);

    localparam int NB      = MAX_WIDTH / 8;
    localparam int BSH     = $clog2(NB);
    // Byte count of the longest vector (MAX_VL elements of 8 bytes) plus rounding.
    localparam int CHUNK_W = VL_W + 4;

    state_e                  r_state;
    state_e                  w_next;
    op_e                     r_op;
    logic [1:0]              r_vsew;
    logic [VL_W-1:0]         r_vl;
    logic                    r_vm;
    logic [MAX_VL-1:0]       r_vmask;
    logic [ADDR_WIDTH-1:0]   r_vs1;
    logic [ADDR_WIDTH-1:0]   r_vs2;
    logic [ADDR_WIDTH-1:0]   r_vd;
    logic [CHUNK_W-1:0]      r_chunk;
    logic [CHUNK_W-1:0]      r_nchunks;
    logic [MAX_WIDTH-1:0]    r_wr_data;
    logic [NB-1:0]           r_wr_be;

    logic [VL_W-1:0]         w_vl_clamp;
    logic [CHUNK_W-1:0]      w_bytes;
    logic [CHUNK_W-1:0]      w_nchunks;
    logic                    w_last;
    logic                    w_busy;
    logic [NB-1:0]           w_mask;
    logic [NB-1:0]           w_be;
    logic [SEW_WIDTH-1:0]    w_sew;

    assign w_vl_clamp = (instr_vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : instr_vl;
    assign w_bytes    = CHUNK_W'(w_vl_clamp) << instr_vsew;
    assign w_nchunks  = (w_bytes + CHUNK_W'(NB - 1)) >> BSH;
    assign w_last     = (r_chunk == (r_nchunks - CHUNK_W'(1)));
    assign w_busy     = (r_state != S_IDLE);
    assign w_sew      = SEW_WIDTH'(vsew_to_therm(r_vsew, SEW_WIDTH));

    simd_add_mask_gen #(
        .MAX_WIDTH (MAX_WIDTH),
        .MAX_VL    (MAX_VL),
        .CHUNK_W   (CHUNK_W),
        .VL_W      (VL_W)
    ) u_mask_gen (
        .i_vsew  (r_vsew),
        .i_chunk (r_chunk),
        .i_vl    (r_vl),
        .i_vm    (r_vm),
        .i_vmask (r_vmask),
        .i_op    (r_op),
        .o_mask  (w_mask),
        .o_be    (w_be)
    );

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        rd_en       = 1'b0;
        wr_valid    = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_next = (w_nchunks == '0) ? S_FIN : S_READ;
                end
            end
            S_READ: begin
                rd_en  = 1'b1;
                w_next = S_EXEC;
            end
            S_EXEC: begin
                w_next = S_WRITE;
            end
            S_WRITE: begin
                wr_valid = 1'b1;
                if (wr_ready) begin
                    w_next = w_last ? S_FIN : S_READ;
                end
            end
            S_FIN: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Outputs are forced to zero outside the phase in which they are meaningful,
    // so a reset or idle sequencer presents a quiet interface.
    assign rd_addr_a = rd_en ? (r_vs2 + ADDR_WIDTH'(r_chunk)) : '0;
    assign rd_addr_b = rd_en ? (r_vs1 + ADDR_WIDTH'(r_chunk)) : '0;
    assign add_sub   = w_busy && ((r_op == OP_SUB) || (r_op == OP_RSUB));
    assign add_rev   = w_busy && (r_op == OP_RSUB);
    assign add_carry = w_busy && (r_op == OP_ADC);
    assign add_sew   = w_busy ? w_sew : '0;
    assign add_mask  = w_busy ? w_mask : '0;
    assign wr_addr   = wr_valid ? (r_vd + ADDR_WIDTH'(r_chunk)) : '0;
    assign wr_data   = wr_valid ? r_wr_data : '0;
    assign wr_be     = wr_valid ? r_wr_be : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= OP_ADD;
            r_vsew    <= '0;
            r_vl      <= '0;
            r_vm      <= 1'b0;
            r_vmask   <= '0;
            r_vs1     <= '0;
            r_vs2     <= '0;
            r_vd      <= '0;
            r_chunk   <= '0;
            r_nchunks <= '0;
            r_wr_data <= '0;
            r_wr_be   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        r_op      <= op_e'(instr_op);
                        r_vsew    <= instr_vsew;
                        r_vl      <= w_vl_clamp;
                        r_vm      <= instr_vm;
                        r_vmask   <= instr_vmask;
                        r_vs1     <= instr_vs1;
                        r_vs2     <= instr_vs2;
                        r_vd      <= instr_vd;
                        r_chunk   <= '0;
                        r_nchunks <= w_nchunks;
                    end
                end
                S_EXEC: begin
                    // Operands arrived this cycle; capture the sum for the write.
                    r_wr_data <= add_result;
                    r_wr_be   <= w_be;
                end
                S_WRITE: begin
                    if (wr_ready && !w_last) begin
                        r_chunk <= r_chunk + CHUNK_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_simd_add_sequencer.sv
module tb_simd_add_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [1:0]  instr_op;
    logic [1:0]  instr_vsew;
    logic [6:0]  instr_vl;
    logic        instr_vm;
    logic [63:0] instr_vmask;
    logic [4:0]  instr_vs1;
    logic [4:0]  instr_vs2;
    logic [4:0]  instr_vd;
    logic        rd_en;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        add_sub;
    logic        add_rev;
    logic        add_carry;
    logic [3:0]  add_sew;
    logic [7:0]  add_mask;
    logic [63:0] add_result;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_be;
    logic        done;

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    simd_add_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_vsew  (instr_vsew),
        .instr_vl    (instr_vl),
        .instr_vm    (instr_vm),
        .instr_vmask (instr_vmask),
        .instr_vs1   (instr_vs1),
        .instr_vs2   (instr_vs2),
        .instr_vd    (instr_vd),
        .rd_en       (rd_en),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .add_sub     (add_sub),
        .add_rev     (add_rev),
        .add_carry   (add_carry),
        .add_sew     (add_sew),
        .add_mask    (add_mask),
        .add_result  (add_result),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_be       (wr_be),
        .done        (done)
    );

    // Stand-in register file + adder: the sum is a fixed scramble of the two
    // word addresses read in the previous cycle.
    function automatic logic [63:0] mix(input logic [4:0] a, input logic [4:0] b);
        return (64'(a) * 64'h9E37_79B9_7F4A_7C15) ^ ({59'd0, b} << 17) ^ 64'(b);
    endfunction

    logic [4:0] rf_a = '0;
    logic [4:0] rf_b = '0;
    always @(posedge clk) begin
        if (rd_en) begin
            rf_a <= rd_addr_a;
            rf_b <= rd_addr_b;
        end
    end
    assign add_result = mix(rf_a, rf_b);

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  vsew;
        logic [6:0]  vl;
        logic        vm;
        logic [63:0] vmask;
        logic [4:0]  vs1;
        logic [4:0]  vs2;
        logic [4:0]  vd;
        int          stall;
        int          exp_nwr;
        logic [7:0]  exp_be0;
        logic [7:0]  exp_be_last;
        logic [7:0]  exp_mask0;
        logic [3:0]  exp_sew;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Runs one instruction and checks every cycle against expectations derived
    // from the vector/byte layout rules (global byte index -> element index).
    task automatic run_instr(input vec_t v, output int n_wr, output logic [7:0] be_first,
                             output logic [7:0] be_last, output logic [7:0] mask_first,
                             output logic [3:0] sew_seen);
        logic [4:0]  e_ra [64];
        logic [4:0]  e_rb [64];
        logic [4:0]  e_wa [64];
        logic [63:0] e_wd [64];
        logic [7:0]  e_be [64];
        logic [7:0]  e_mk [64];
        logic [3:0]  e_sew;
        int vle, nch, esz, budget, acc_cyc, last_evt, exp_rd_cyc, exec_cyc;
        int rd_i, wr_i, stall_cnt;
        bit seen_done;

        vle = (v.vl > 7'd64) ? 64 : int'(v.vl);
        esz = 1 << v.vsew;
        nch = (vle * esz + 7) / 8;
        case (v.vsew)
            2'd0: e_sew = 4'b1111;
            2'd1: e_sew = 4'b0111;
            2'd2: e_sew = 4'b0011;
            default: e_sew = 4'b0001;
        endcase
        for (int c = 0; c < nch; c++) begin
            e_ra[c] = 5'((int'(v.vs2) + c) % 32);
            e_rb[c] = 5'((int'(v.vs1) + c) % 32);
            e_wa[c] = 5'((int'(v.vd) + c) % 32);
            e_wd[c] = mix(e_ra[c], e_rb[c]);
            e_be[c] = '0;
            e_mk[c] = '0;
            for (int by = 0; by < 8; by++) begin
                int g, e;
                bit act, mb;
                g   = c * 8 + by;
                e   = g / esz;
                act = (e < vle);
                mb  = act ? v.vmask[e] : 1'b0;
                e_be[c][by] = act && (v.vm || v.op == 2'd3 || mb);
                e_mk[c][by] = act && mb && (g % esz == 0);
            end
        end

        n_wr = 0; be_first = '0; be_last = '0; mask_first = '0; sew_seen = '0;
        rd_i = 0; wr_i = 0; stall_cnt = 0; seen_done = 0; exec_cyc = -10;
        budget = 50 + nch * (v.stall + 6);

        @(negedge clk);
        chk("idle_ready", instr_ready, 1'b1);
        chk("idle_quiet", {rd_en, wr_valid, done, add_sub, add_rev, add_carry, add_sew, add_mask}, '0);
        instr_op = v.op; instr_vsew = v.vsew; instr_vl = v.vl; instr_vm = v.vm;
        instr_vmask = v.vmask; instr_vs1 = v.vs1; instr_vs2 = v.vs2; instr_vd = v.vd;
        instr_valid = 1'b1;
        acc_cyc = cyc;
        last_evt = acc_cyc;
        exp_rd_cyc = acc_cyc + 1;
        @(posedge clk);
        #1 instr_valid = 1'b0;

        for (int k = 0; k < budget && !seen_done; k++) begin
            @(negedge clk);
            chk("busy_ready", instr_ready, 1'b0);
            if (rd_en) begin
                chk("rd_count", rd_i < nch, 1'b1);
                chk("rd_timing", cyc, exp_rd_cyc);
                if (rd_i < nch) begin
                    chk("rd_addr_a", rd_addr_a, e_ra[rd_i]);
                    chk("rd_addr_b", rd_addr_b, e_rb[rd_i]);
                end
                exec_cyc = cyc + 1;
                rd_i++;
            end
            if (cyc == exec_cyc && rd_i >= 1 && rd_i <= nch) begin
                chk("exec_no_rd_wr", {rd_en, wr_valid}, 2'b00);
                chk("add_mask", add_mask, e_mk[rd_i-1]);
                chk("add_sew", add_sew, e_sew);
                chk("add_ctl", {add_sub, add_rev, add_carry},
                    {v.op == 2'd1 || v.op == 2'd2, v.op == 2'd2, v.op == 2'd3});
                if (rd_i == 1) begin
                    mask_first = add_mask;
                    sew_seen = add_sew;
                end
            end
            wr_ready = 1'b0;
            if (wr_valid) begin
                chk("wr_count", wr_i < nch, 1'b1);
                if (wr_i < nch) begin
                    if (stall_cnt == 0) chk("wr_timing", cyc, exec_cyc + 1);
                    chk("wr_addr", wr_addr, e_wa[wr_i]);
                    chk("wr_data", wr_data, e_wd[wr_i]);
                    chk("wr_be", wr_be, e_be[wr_i]);
                    if (stall_cnt >= v.stall) begin
                        wr_ready = 1'b1;
                        if (wr_i == 0) be_first = wr_be;
                        be_last = wr_be;
                        wr_i++;
                        stall_cnt = 0;
                        last_evt = cyc;
                        exp_rd_cyc = cyc + 1;
                    end else begin
                        stall_cnt++;
                    end
                end
            end
            if (done) begin
                chk("done_nwr", wr_i, nch);
                chk("done_nrd", rd_i, nch);
                chk("done_timing", cyc, last_evt + 1);
                seen_done = 1;
            end
        end
        chk("done_seen_in_budget", seen_done, 1'b1);
        n_wr = wr_i;
    endtask

    vec_t tbl [7];

    initial begin
        int nwr;
        logic [7:0] bf, bl, mf;
        logic [3:0] sw;
        vec_t rv;

        tbl[0] = '{2'd0, 2'd3, 7'd2,   1'b1, 64'h0,    5'd8,  5'd4,  5'd12, 0, 2,  8'hFF, 8'hFF, 8'h00, 4'h1};
        tbl[1] = '{2'd1, 2'd0, 7'd10,  1'b0, 64'h2AA,  5'd3,  5'd7,  5'd20, 0, 2,  8'hAA, 8'h02, 8'hAA, 4'hF};
        tbl[2] = '{2'd3, 2'd1, 7'd4,   1'b0, 64'h5,    5'd1,  5'd2,  5'd3,  1, 1,  8'hFF, 8'hFF, 8'h11, 4'h7};
        tbl[3] = '{2'd0, 2'd2, 7'd0,   1'b1, 64'hFFFF, 5'd5,  5'd6,  5'd7,  0, 0,  8'h00, 8'h00, 8'h00, 4'h0};
        tbl[4] = '{2'd2, 2'd2, 7'd3,   1'b0, 64'h6,    5'd31, 5'd30, 5'd31, 5, 2,  8'hF0, 8'h0F, 8'h10, 4'h3};
        tbl[5] = '{2'd0, 2'd3, 7'd100, 1'b1, 64'h0,    5'd0,  5'd16, 5'd24, 0, 64, 8'hFF, 8'hFF, 8'h00, 4'h1};
        tbl[6] = '{2'd1, 2'd0, 7'd3,   1'b1, 64'hFF,   5'd9,  5'd9,  5'd9,  2, 1,  8'h07, 8'h07, 8'h07, 4'hF};

        rst = 1'b1; instr_valid = 1'b0; wr_ready = 1'b0;
        instr_op = '0; instr_vsew = '0; instr_vl = '0; instr_vm = 1'b0;
        instr_vmask = '0; instr_vs1 = '0; instr_vs2 = '0; instr_vd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", instr_ready, 1'b1);
        chk("reset_outputs", {rd_en, rd_addr_a, rd_addr_b, add_sub, add_rev, add_carry, add_sew,
                              add_mask, wr_valid, wr_addr, wr_be, done}, '0);
        chk("reset_wr_data", wr_data, 64'h0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_instr(tbl[i], nwr, bf, bl, mf, sw);
            chk($sformatf("tbl%0d_nwr", i), nwr, tbl[i].exp_nwr);
            if (tbl[i].exp_nwr > 0) begin
                chk($sformatf("tbl%0d_be_first", i), bf, tbl[i].exp_be0);
                chk($sformatf("tbl%0d_be_last", i), bl, tbl[i].exp_be_last);
                chk($sformatf("tbl%0d_mask_first", i), mf, tbl[i].exp_mask0);
                chk($sformatf("tbl%0d_sew", i), sw, tbl[i].exp_sew);
            end
        end

        // Reset while the first operand word is in the adder: no write may follow.
        @(negedge clk);
        instr_op = 2'd0; instr_vsew = 2'd3; instr_vl = 7'd2; instr_vm = 1'b1;
        instr_vmask = '0; instr_vs1 = 5'd8; instr_vs2 = 5'd4; instr_vd = 5'd12;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("rst_seq_read", rd_en, 1'b1);
        @(negedge clk);
        chk("rst_seq_exec", {rd_en, wr_valid, instr_ready}, 3'b000);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_seq_idle_ready", instr_ready, 1'b1);
        chk("rst_seq_idle_outputs", {rd_en, wr_valid, done, add_sub, add_rev, add_carry, add_sew,
                                     add_mask, wr_addr, wr_be}, '0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_seq_no_activity", {rd_en, wr_valid, done}, 3'b000);
        end

        // Randomized instructions against the reference expectations.
        for (int i = 0; i < 30; i++) begin
            rv.op    = 2'($urandom_range(0, 3));
            rv.vsew  = 2'($urandom_range(0, 3));
            rv.vl    = 7'($urandom_range(0, 70));
            rv.vm    = 1'($urandom_range(0, 1));
            rv.vmask = {$urandom, $urandom};
            rv.vs1   = 5'($urandom_range(0, 31));
            rv.vs2   = 5'($urandom_range(0, 31));
            rv.vd    = 5'($urandom_range(0, 31));
            rv.stall = $urandom_range(0, 3);
            rv.exp_nwr = 0; rv.exp_be0 = '0; rv.exp_be_last = '0;
            rv.exp_mask0 = '0; rv.exp_sew = '0;
            run_instr(rv, nwr, bf, bl, mf, sw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
